// File: rtl/muldiv_arbiter_if.sv
// Bundle of the requester-side and unit-side signals of the two-port multiply/divide arbiter.
// The arbiter takes the slave modport. The requesters and the unit take the master modport.
interface muldiv_arbiter_if #(
    parameter int unsigned N = 16
);
    logic [1:0]     req_valid_i;
    logic [5:0]     req_op_i;
    logic [2*N-1:0] req_a_i;
    logic [2*N-1:0] req_b_i;
    logic [1:0]     req_ready_o;
    logic [1:0]     resp_valid_o;
    logic [1:0]     resp_ready_i;
    logic [N-1:0]   resp_result_o;
    logic           resp_err_o;
    logic           md_valid_o;
    logic [7:0]     md_op_o;
    logic [N-1:0]   md_ra_o;
    logic [N-1:0]   md_rb_o;
    logic           md_stall_i;
    logic           md_ready_i;
    logic [N-1:0]   md_result_i;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, resp_ready_i,
        input  md_stall_i, md_ready_i, md_result_i,
        output req_ready_o, resp_valid_o, resp_result_o, resp_err_o,
        output md_valid_o, md_op_o, md_ra_o, md_rb_o
    );

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, resp_ready_i,
        output md_stall_i, md_ready_i, md_result_i,
        input  req_ready_o, resp_valid_o, resp_result_o, resp_err_o,
        input  md_valid_o, md_op_o, md_ra_o, md_rb_o
    );
endinterface

// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter that shares one multiply/divide unit between two requesters.
// It keeps one operation in flight and aborts it with an error response when a WAIT timeout expires.
module muldiv_arbiter #(
    parameter int unsigned N       = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    muldiv_arbiter_if.slave  bus
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic         id;
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } txn_t;

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    txn_t          txn_q, txn_d;
    logic [N-1:0]  result_q, result_d;
    logic          err_q, err_d;

    logic          gnt_vld_c;
    logic          gnt_id_c;
    logic [1:0]    req_ready_c;
    logic          md_valid_c;

    // When both requesters are valid, the pointer decides the grant. A lone request wins outright.
    always_comb begin
        gnt_vld_c = |bus.req_valid_i;
        gnt_id_c  = ptr_q;
        if (bus.req_valid_i == 2'b01) begin
            gnt_id_c = 1'b0;
        end else if (bus.req_valid_i == 2'b10) begin
            gnt_id_c = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        txn_d       = txn_q;
        result_d    = result_q;
        err_d       = err_q;
        req_ready_c = 2'b00;
        md_valid_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt_vld_c) begin
                    req_ready_c = 2'b01 << gnt_id_c;
                    txn_d.id    = gnt_id_c;
                    txn_d.op    = gnt_id_c ? bus.req_op_i[5:3]     : bus.req_op_i[2:0];
                    txn_d.a     = gnt_id_c ? bus.req_a_i[2*N-1:N] : bus.req_a_i[N-1:0];
                    txn_d.b     = gnt_id_c ? bus.req_b_i[2*N-1:N] : bus.req_b_i[N-1:0];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.md_stall_i) begin
                    md_valid_c = 1'b1;
                    cnt_d      = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // A result that arrives on the final timeout cycle still wins over the abort.
                if (bus.md_ready_i) begin
                    result_d = bus.md_result_i;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    result_d = '1;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready_i[txn_q.id]) begin
                    ptr_d   = ~txn_q.id;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            cnt_q    <= '0;
            txn_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            txn_q    <= txn_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // The accept and issue strobes come from combinational logic, so they are gated by reset.
    assign bus.req_ready_o   = rst_ni ? req_ready_c : 2'b00;
    assign bus.md_valid_o    = rst_ni & md_valid_c;
    assign bus.md_op_o       = bus.md_valid_o ? (8'h01 << txn_q.op) : 8'h00;
    assign bus.md_ra_o       = txn_q.a;
    assign bus.md_rb_o       = txn_q.b;
    assign bus.resp_valid_o  = (state_q == RESP) ? (2'b01 << txn_q.id) : 2'b00;
    assign bus.resp_result_o = result_q;
    assign bus.resp_err_o    = err_q;

endmodule

// File: doc/muldiv_arbiter.md
MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 SHALL have parameter: N, 16, operand/result width, which SHALL match the width of the shared multiply/divide unit.
REQ-002 SHALL have parameter: TIMEOUT, 255, maximum WAIT cycles before abort (1..255).
REQ-003 SHALL have port: clk_i  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port: rst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have port: req_valid_i  in  2  per-requester request valid, bit r = requester r.
REQ-006 SHALL have port: req_op_i  in  6  per-requester op, [3r+2:3r]: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port: req_a_i  in  2N  per-requester operand A, [N(r+1)-1:Nr].
REQ-008 SHALL have port: req_b_i  in  2N  per-requester operand B, [N(r+1)-1:Nr].
REQ-009 SHALL have port: req_ready_o  out  2  per-requester accept; a transfer occurs when valid and ready are both high in the same cycle.
REQ-010 SHALL have port: resp_valid_o  out  2  per-requester response valid.
REQ-011 SHALL have port: resp_ready_i  in  2  per-requester response accept.
REQ-012 SHALL have port: resp_result_o  out  N  result, shared by both requesters.
REQ-013 SHALL have port: resp_err_o  out  1  timeout abort flag; meaningful only while a resp_valid_o bit is high.
REQ-014 SHALL have port: md_valid_o  out  1  issue pulse to the unit.
REQ-015 SHALL have port: md_op_o  out  8  one-hot op {remu,rem,divu,div,mulhu,mulhsu,mulh,mul}, bit k = op code k.
REQ-016 SHALL have port: md_ra_o  out  N  operand A to the unit.
REQ-017 SHALL have port: md_rb_o  out  N  operand B to the unit.
REQ-018 SHALL have port: md_stall_i  in  1  unit busy.
REQ-019 SHALL have port: md_ready_i  in  1  unit result valid.
REQ-020 SHALL have port: md_result_i  in  N  unit result.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, plus a 1-bit round-robin pointer ptr.
REQ-022 In IDLE, SHALL grant the single valid requester; if both are valid, SHALL grant requester ptr.
REQ-023 In IDLE, SHALL drive req_ready_o combinationally: only the granted bit high, all bits low in every other state.
REQ-024 On a grant, SHALL capture op, A, B and grant id into registers and go to ISSUE.
REQ-025 In ISSUE with md_stall_i=0, SHALL assert md_valid_o for exactly one cycle with registered operands, then go to WAIT.
REQ-026 In ISSUE with md_stall_i=1, SHALL hold md_valid_o low and stay in ISSUE.
REQ-027 SHALL drive md_op_o=0 whenever md_valid_o=0, and exactly one bit when md_valid_o=1.
REQ-028 SHALL issue at most one operation to the unit until md_ready_i returns for it.
REQ-029 In WAIT, SHALL count cycles from 0; on md_ready_i=1, SHALL register md_result_i, clear err and go to RESP.
REQ-030 If the WAIT count reaches TIMEOUT without md_ready_i, SHALL set result to all-ones, set err=1 and go to RESP.
REQ-031 If md_ready_i and timeout occur in the same cycle, md_ready_i SHALL take priority.
REQ-032 SHALL ignore md_ready_i outside WAIT.
REQ-033 In RESP, SHALL hold resp_valid_o[grant]=1 with resp_result_o and resp_err_o stable until resp_ready_i[grant]=1.
REQ-034 On the RESP handshake, SHALL set ptr to ~grant, go to IDLE, and accept no new request in that same cycle.
REQ-035 Minimum latency from accept to resp_valid_o SHALL be 2 cycles plus the unit latency.
REQ-036 SHALL pass arithmetic results, including divide-by-zero and overflow values, unmodified from the unit.

Reset
REQ-037 While rst_ni=0, regardless of state, SHALL immediately force state=IDLE, ptr=0, WAIT count=0.
REQ-038 While rst_ni=0, SHALL force outputs req_ready_o=0, resp_valid_o=0, resp_result_o=0, resp_err_o=0, md_valid_o=0, md_op_o=0, md_ra_o=0, md_rb_o=0.
REQ-039 SHALL discard any in-flight operation on reset and SHALL NOT produce a response for it after reset release.

Verification
REQ-040 Bench SHALL cover: req0 MUL A=0x0003 B=0x0005 -> md_op_o=0x01 pulsed one cycle; resp_valid_o=2'b01, result 0x000F, err=0.
REQ-041 Bench SHALL cover: after reset, both valid same cycle, req0 DIVU 100/7 and req1 REMU 100/7 -> req0 served first (result 0x000E), then req1 (result 0x0002).
REQ-042 Bench SHALL cover: req1 DIV 0x8000/0xFFFF, then DIVU 0x1234/0x0000 -> results 0x8000 and 0xFFFF, both err=0.
REQ-043 Bench SHALL cover: resp_ready_i low for 10 cycles -> resp_valid_o and result stable, req_ready_o=0, md_valid_o=0 throughout.
REQ-044 Bench SHALL cover: md_stall_i high 3 cycles in ISSUE, then md_ready_i withheld -> md_valid_o only after stall drops; at TIMEOUT, resp_err_o=1 and result 0xFFFF.
REQ-045 Bench SHALL cover: rst_ni low mid-WAIT -> all outputs 0 the same cycle; no response after release; next grant goes to req0.
